cpu_mem_responder: RTL and testbench
====================================

Name: cpu_mem_responder

Overview:
Memory-side responder for the pipelined CPU's three memory channels: instruction fetch (read), load (read) and store (write). It holds a single 2^ADDR_W x DATA_W word array. Reads are registered with 1-cycle latency. A boot FSM fills the array from a valid/ready stream and holds the core in reset via core_resetn until loading completes. Sits between the CPU top and the testbench/boot source.

Parameters:
ADDR_W, 11, word address width; depth = 2^ADDR_W
DATA_W, 32, word width
BOOT_FILL, 32'h0000_0000, value returned on both read ports while not in RUN (NOOP encoding)

Ports:
clk  input  1  system clock
resetn  input  1  reset, asynchronous active-low
read_mem_ir  input  1  instruction read enable
mem_radrs_ir  input  ADDR_W  instruction read address
instruction_fetch  output  DATA_W  instruction read data
read_mem_str  input  1  load read enable
mem_radrs_ld  input  ADDR_W  load read address
mem_store_data  output  DATA_W  load read data
write_mem  input  1  store write enable
mem_wadrs  input  ADDR_W  store write address
mem_wdata  input  DATA_W  store write data
boot_valid  input  1  boot word valid
boot_data  input  DATA_W  boot word
boot_last  input  1  qualifies final boot word
boot_ready  output  1  responder accepts boot word
core_resetn  output  1  active-low reset to CPU, registered
boot_done  output  1  high in RUN

Behaviour:
- Async reset: FSM=BOOT, boot_addr=0, instruction_fetch=mem_store_data=BOOT_FILL, boot_ready=0, core_resetn=0, boot_done=0. The array is not cleared.
- FSM BOOT: boot_ready=1. When boot_valid&&boot_ready, write boot_data to array[boot_addr] and increment boot_addr. Go to RUN if boot_last=1 on that beat, or if boot_addr==2^ADDR_W-1 (auto-stop, no wrap). CPU ports are ignored: writes dropped, read outputs forced to BOOT_FILL.
- FSM RUN: boot_ready=0 and boot_done=1. core_resetn rises on the cycle after RUN is entered, so the CPU sees 1 cycle of reset with memory already valid. boot_valid is ignored. RUN is left only by resetn.
- Read ports (RUN): when read_mem_ir=1 at edge N, instruction_fetch = array[mem_radrs_ir] after edge N, stable through cycle N+1. The load port behaves the same with read_mem_str/mem_radrs_ld. With the enable low, the output holds its last value; the CPU relies on the hold between EXECUTE and WB.
- Both ports may read the same address in the same cycle; both return identical data.
- Write port (RUN): when write_mem=1, array[mem_wadrs] <= mem_wdata at the edge. Write-wins ordering applies for later reads.
- Read-during-write to the same address in the same cycle: see Optional Feature.
- Reset mid-boot: boot_addr returns to 0 and the words already written remain. Reset in RUN returns to BOOT and core_resetn drops asynchronously with resetn.

Optional Feature:
MEM_WR_BYPASS_EN.
- Defined: a read whose address equals mem_wadrs while write_mem=1 in the same cycle returns mem_wdata (new data), on each read port independently.
- Undefined: such a read returns the old array contents (read-first).
- Boot writes never bypass in either case.

Decomposition:
- Shared package cpu_mem_pkg: ADDR_W/DATA_W defaults, NOOP word constant, boot FSM state encoding (BOOT, RUN).
- One sub-module, mem_array_1w2r: storage with one write port and two registered read ports, plus bypass muxing under MEM_WR_BYPASS_EN.
- FSM, boot counter, core_resetn register and read-output forcing stay in the top module.

Test Plan:
- Boot 3 words 0xA0000001, 0xA0000002, 0xA0000003 (last on the third) -> boot_done=1 the cycle after; core_resetn=1 one cycle later; read_mem_ir@addr 1 -> instruction_fetch=0xA0000002 next cycle.
- During BOOT, write_mem@addr 5 data 0xDEAD and read_mem_str@5 -> mem_store_data=0x0; after RUN, read@5 returns the boot-loaded value, not 0xDEAD.
- RUN: write_mem@addr 0x10 data 0x1234 with read_mem_str@0x10 in the same cycle -> 0x1234 with MEM_WR_BYPASS_EN, prior contents without; the next read returns 0x1234 either way.
- Stream 2048 words without boot_last -> RUN entered on the word at address 2047; boot_ready=0 and the 2049th boot_valid is ignored; address 0 is intact.
- Read_mem_str@7 once, then hold the enable low 3 cycles while writing addr 7 -> mem_store_data unchanged.
- Assert resetn low after 2 boot words, then release -> boot_addr restarts at 0; outputs return to reset values immediately (async).

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory responder: default geometry,
// the NOOP fill word and the boot FSM state encoding.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 11;
  localparam int unsigned DATA_W_DEF = 32;
  localparam logic [31:0] NOOP_WORD  = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } boot_state_e;

endpackage

// File: rtl/mem_array_1w2r.sv
// Word array with one write port and two registered read ports.
// Optional macro MEM_WR_BYPASS_EN: same-cycle write data forwarded to reads.
module mem_array_1w2r
  import cpu_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W = ADDR_W_DEF,
  parameter int unsigned       DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] FILL   = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_a_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic              re_b_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_a_d, rdata_a_q;
  logic [DATA_W-1:0] rdata_b_d, rdata_b_q;

  // Storage is deliberately left out of reset so boot contents survive resetn.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_comb begin
    rdata_a_d = mem_q[raddr_a_i];
    rdata_b_d = mem_q[raddr_b_i];
`ifdef MEM_WR_BYPASS_EN
    if (we_i && (waddr_i == raddr_a_i)) rdata_a_d = wdata_i;
    if (we_i && (waddr_i == raddr_b_i)) rdata_b_d = wdata_i;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_a_q <= FILL;
      rdata_b_q <= FILL;
    end else begin
      if (re_a_i) rdata_a_q <= rdata_a_d;
      if (re_b_i) rdata_b_q <= rdata_b_d;
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory responder for the CPU's fetch/load/store channels with boot loader.
// Optional macro MEM_WR_BYPASS_EN enables write-to-read forwarding in RUN.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] BOOT_FILL = DATA_W'(NOOP_WORD)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              read_mem_ir,
  input  logic [ADDR_W-1:0] mem_radrs_ir,
  output logic [DATA_W-1:0] instruction_fetch,
  input  logic              read_mem_str,
  input  logic [ADDR_W-1:0] mem_radrs_ld,
  output logic [DATA_W-1:0] mem_store_data,
  input  logic              write_mem,
  input  logic [ADDR_W-1:0] mem_wadrs,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              boot_valid,
  input  logic [DATA_W-1:0] boot_data,
  input  logic              boot_last,
  output logic              boot_ready,
  output logic              core_resetn,
  output logic              boot_done
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] boot_addr_q, boot_addr_d;
  logic              boot_ready_q, boot_ready_d;
  logic              core_resetn_q, core_resetn_d;

  logic              run, accept;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] rd_ir, rd_ld;

  assign run    = (state_q == RUN);
  assign accept = boot_ready_q && boot_valid;

  // boot_ready is registered so it is low in reset yet tracks the next state.
  always_comb begin
    state_d       = state_q;
    boot_addr_d   = boot_addr_q;
    if (accept) begin
      boot_addr_d = boot_addr_q + ADDR_ONE;
      if (boot_last || (boot_addr_q == '1)) state_d = RUN;
    end
    boot_ready_d  = (state_d == BOOT);
    core_resetn_d = run;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= BOOT;
      boot_addr_q   <= '0;
      boot_ready_q  <= 1'b0;
      core_resetn_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      boot_addr_q   <= boot_addr_d;
      boot_ready_q  <= boot_ready_d;
      core_resetn_q <= core_resetn_d;
    end
  end

  // CPU reads are gated in BOOT, so boot writes can never be forwarded.
  always_comb begin
    arr_we    = run ? write_mem : accept;
    arr_waddr = run ? mem_wadrs : boot_addr_q;
    arr_wdata = run ? mem_wdata : boot_data;
  end

  mem_array_1w2r #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .FILL   (BOOT_FILL)
  ) u_array (
    .clk_i     (clk),
    .rst_ni    (resetn),
    .we_i      (arr_we),
    .waddr_i   (arr_waddr),
    .wdata_i   (arr_wdata),
    .re_a_i    (run && read_mem_ir),
    .raddr_a_i (mem_radrs_ir),
    .rdata_a_o (rd_ir),
    .re_b_i    (run && read_mem_str),
    .raddr_b_i (mem_radrs_ld),
    .rdata_b_o (rd_ld)
  );

  assign instruction_fetch = run ? rd_ir : BOOT_FILL;
  assign mem_store_data    = run ? rd_ld : BOOT_FILL;
  assign boot_ready        = boot_ready_q;
  assign core_resetn       = core_resetn_q;
  assign boot_done         = run;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: read expectations are queued at
// issue time and popped by a monitor one edge later.
module tb_cpu_mem_responder;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;

`ifdef MEM_WR_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'h0000_1234;
`else
  localparam logic [31:0] BYP_EXP = 32'hB000_0010;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          read_mem_ir = 1'b0;
  logic [AW-1:0] mem_radrs_ir = '0;
  logic [DW-1:0] instruction_fetch;
  logic          read_mem_str = 1'b0;
  logic [AW-1:0] mem_radrs_ld = '0;
  logic [DW-1:0] mem_store_data;
  logic          write_mem = 1'b0;
  logic [AW-1:0] mem_wadrs = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          boot_valid = 1'b0;
  logic [DW-1:0] boot_data = '0;
  logic          boot_last = 1'b0;
  logic          boot_ready;
  logic          core_resetn;
  logic          boot_done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] ir_q[$];
  logic [DW-1:0] ld_q[$];
  logic          ir_fire = 1'b0;
  logic          ld_fire = 1'b0;

  always #5 clk = ~clk;

  cpu_mem_responder #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .BOOT_FILL (32'h0000_0000)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .read_mem_ir       (read_mem_ir),
    .mem_radrs_ir      (mem_radrs_ir),
    .instruction_fetch (instruction_fetch),
    .read_mem_str      (read_mem_str),
    .mem_radrs_ld      (mem_radrs_ld),
    .mem_store_data    (mem_store_data),
    .write_mem         (write_mem),
    .mem_wadrs         (mem_wadrs),
    .mem_wdata         (mem_wdata),
    .boot_valid        (boot_valid),
    .boot_data         (boot_data),
    .boot_last         (boot_last),
    .boot_ready        (boot_ready),
    .core_resetn       (core_resetn),
    .boot_done         (boot_done)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: a read issued at an edge is checked at the following negedge.
  always @(posedge clk) begin
    ir_fire <= read_mem_ir;
    ld_fire <= read_mem_str;
  end

  always @(negedge clk) begin
    if (ir_fire) begin
      if (ir_q.size() == 0) chk("ir_unexpected", instruction_fetch, 32'hxxxx_xxxx);
      else chk("ir_read", instruction_fetch, ir_q.pop_front());
    end
    if (ld_fire) begin
      if (ld_q.size() == 0) chk("ld_unexpected", mem_store_data, 32'hxxxx_xxxx);
      else chk("ld_read", mem_store_data, ld_q.pop_front());
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd_ir(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    read_mem_ir  = 1'b1;
    mem_radrs_ir = a;
    ir_q.push_back(exp);
  endtask

  task automatic rd_ld(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    read_mem_str = 1'b1;
    mem_radrs_ld = a;
    ld_q.push_back(exp);
  endtask

  task automatic idle();
    read_mem_ir  = 1'b0;
    read_mem_str = 1'b0;
    write_mem    = 1'b0;
    boot_valid   = 1'b0;
    boot_last    = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 8 && !boot_ready; i++) tick();
    chk("boot_ready_up", {31'd0, boot_ready}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_core_resetn"}, {31'd0, core_resetn}, 32'd0);
    chk({tag, "_boot_done"}, {31'd0, boot_done}, 32'd0);
    chk({tag, "_boot_ready"}, {31'd0, boot_ready}, 32'd0);
    chk({tag, "_ifetch"}, instruction_fetch, 32'd0);
    chk({tag, "_ldata"}, mem_store_data, 32'd0);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    chk_reset_outputs("por");
    resetn = 1'b1;
    wait_ready();

    // Full 2048-word stream without boot_last; CPU accesses during BOOT
    for (int i = 0; i < 2048; i++) begin
      boot_valid = 1'b1;
      boot_data  = 32'hB000_0000 | i;
      if (i == 3) begin
        write_mem = 1'b1;
        mem_wadrs = 11'd5;
        mem_wdata = 32'h0000_DEAD;
        rd_ld(11'd5, 32'h0);
        rd_ir(11'd5, 32'h0);
      end
      if (i == 2047) begin
        chk("pre_last_boot_done", {31'd0, boot_done}, 32'd0);
        chk("pre_last_boot_ready", {31'd0, boot_ready}, 32'd1);
      end
      tick();
      idle();
    end
    chk("auto_stop_boot_done", {31'd0, boot_done}, 32'd1);
    chk("auto_stop_boot_ready", {31'd0, boot_ready}, 32'd0);
    chk("auto_stop_core_resetn", {31'd0, core_resetn}, 32'd0);
    boot_valid = 1'b1;
    boot_data  = 32'hFFFF_FFFF;
    tick();
    idle();
    chk("core_resetn_rise", {31'd0, core_resetn}, 32'd1);
    chk("extra_beat_ready", {31'd0, boot_ready}, 32'd0);
    rd_ir(11'd0, 32'hB000_0000);
    rd_ld(11'd5, 32'hB000_0005);
    tick();
    idle();
    rd_ir(11'd2047, 32'hB000_07FF);
    tick();
    idle();

    // Reset after 2 boot words, then 3-word boot restarting at address 0
    resetn = 1'b0;
    #1;
    chk_reset_outputs("run_rst");
    tick();
    resetn = 1'b1;
    wait_ready();
    boot_valid = 1'b1;
    boot_data  = 32'hC000_0000;
    tick();
    boot_data  = 32'hC000_0001;
    tick();
    idle();
    resetn = 1'b0;
    #1;
    chk_reset_outputs("boot_rst");
    tick();
    resetn = 1'b1;
    wait_ready();
    for (int i = 0; i < 3; i++) begin
      boot_valid = 1'b1;
      boot_data  = 32'hA000_0001 + i;
      boot_last  = (i == 2);
      tick();
      idle();
      if (i < 2) chk("mid_boot_done", {31'd0, boot_done}, 32'd0);
    end
    chk("boot3_done", {31'd0, boot_done}, 32'd1);
    chk("boot3_core_resetn_low", {31'd0, core_resetn}, 32'd0);
    tick();
    chk("boot3_core_resetn_high", {31'd0, core_resetn}, 32'd1);
    rd_ir(11'd1, 32'hA000_0002);
    rd_ld(11'd0, 32'hA000_0001);
    tick();
    idle();
    rd_ir(11'd2, 32'hA000_0003);
    rd_ld(11'd3, 32'hB000_0003);
    tick();
    idle();

    // Same-address reads on both ports
    rd_ir(11'h20, 32'hB000_0020);
    rd_ld(11'h20, 32'hB000_0020);
    tick();
    idle();

    // Read-during-write on both ports, then plain reads of the new value
    write_mem = 1'b1;
    mem_wadrs = 11'h10;
    mem_wdata = 32'h0000_1234;
    rd_ld(11'h10, BYP_EXP);
    rd_ir(11'h10, BYP_EXP);
    tick();
    idle();
    rd_ld(11'h10, 32'h0000_1234);
    rd_ir(11'h10, 32'h0000_1234);
    tick();
    idle();

    // Load output holds while enable is low, even as the address is rewritten
    rd_ld(11'd7, 32'hB000_0007);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      write_mem = 1'b1;
      mem_wadrs = 11'd7;
      mem_wdata = 32'h0000_7770 + k;
      tick();
      chk("ld_hold", mem_store_data, 32'hB000_0007);
    end
    idle();
    rd_ld(11'd7, 32'h0000_7772);
    tick();
    idle();
    tick();

    chk("ir_queue_empty", ir_q.size(), 32'd0);
    chk("ld_queue_empty", ld_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
